// File: rtl/voice_mixer.sv
// voice_mixer: per-frame snapshot of N voice samples, one gained MAC per cycle,
// master gain with floor-rounding shift, 16-bit saturation, registered output.
module voice_mixer #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned GAIN_BITS  = 8
) (
  input  logic                            mclk,
  input  logic                            rst,
  input  logic                            pblrc,
  input  logic [16*NUM_VOICES-1:0]        voice_samples,
  input  logic [GAIN_BITS*NUM_VOICES-1:0] voice_gain,
  input  logic [NUM_VOICES-1:0]           voice_enable,
  input  logic [GAIN_BITS-1:0]            master_gain,
  input  logic                            clip_clear,
  output logic signed [15:0]              mix_out,
  output logic                            mix_valid,
  output logic                            clip,
  output logic                            overrun
);

  localparam int unsigned TW    = 17 + GAIN_BITS;
  localparam int unsigned AW    = TW + $clog2(NUM_VOICES);
  localparam int unsigned PRW   = AW + GAIN_BITS + 1;
  localparam int unsigned SHIFT = 2 * (GAIN_BITS - 1);
  localparam int unsigned IDXW  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(NUM_VOICES - 1);
  localparam logic signed [PRW-1:0] SAT_MAX  = PRW'(32767);
  localparam logic signed [PRW-1:0] SAT_MIN  = PRW'(-32768);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SCALE,
    S_OUT
  } state_t;

  state_t r_state, w_next;

  logic                  r_pblrc_d;
  logic                  r_armed;
  logic signed [15:0]    r_samp [NUM_VOICES];
  logic [GAIN_BITS-1:0]  r_gain [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_en;
  logic [GAIN_BITS-1:0]  r_master;
  logic signed [AW-1:0]  r_acc;
  logic [IDXW-1:0]       r_idx;
  logic signed [15:0]    r_mix;
  logic                  r_valid;
  logic                  r_sat_evt;
  logic                  r_clip;
  logic                  r_overrun;

  logic                  w_frame_start;
  logic signed [TW-1:0]  w_term;
  logic signed [PRW-1:0] w_prod;
  logic signed [PRW-1:0] w_shift;
  logic signed [15:0]    w_sat;
  logic                  w_clip_evt;

  // r_armed only rises once pblrc has been seen low, so a pblrc already high
  // when reset releases is not mistaken for a rising edge.
  assign w_frame_start = pblrc & ~r_pblrc_d & r_armed;

  assign mix_out   = r_mix;
  assign mix_valid = r_valid;
  assign clip      = r_clip;
  assign overrun   = r_overrun;

  // State register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_start) w_next = S_ACCUM;
      S_ACCUM: if (r_idx == LAST_IDX) w_next = S_SCALE;
      S_SCALE: w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Gained contribution of the voice currently addressed by r_idx
  always_comb begin
    w_term = '0;
    if (r_en[r_idx])
      w_term = TW'(r_samp[r_idx]) * TW'($signed({1'b0, r_gain[r_idx]}));
  end

  // Master gain, floor-rounding shift and 16-bit saturation
  always_comb begin
    w_prod     = PRW'(r_acc) * PRW'($signed({1'b0, r_master}));
    w_shift    = w_prod >>> SHIFT;
    w_sat      = w_shift[15:0];
    w_clip_evt = 1'b0;
    if (w_shift > SAT_MAX) begin
      w_sat      = 16'sh7fff;
      w_clip_evt = 1'b1;
    end else if (w_shift < SAT_MIN) begin
      w_sat      = -16'sh8000;
      w_clip_evt = 1'b1;
    end
  end

  // Datapath: snapshot, accumulate, output register and status flags
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_pblrc_d <= 1'b0;
      r_armed   <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        r_samp[i] <= '0;
        r_gain[i] <= '0;
      end
      r_en      <= '0;
      r_master  <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_mix     <= '0;
      r_valid   <= 1'b0;
      r_sat_evt <= 1'b0;
      r_clip    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pblrc_d <= pblrc;
      r_armed   <= r_armed | ~pblrc;
      r_valid   <= 1'b0;
      if (w_frame_start && (r_state != S_IDLE)) r_overrun <= 1'b1;
      // The saturation event is registered in SCALE and applied in OUT, so a
      // clip_clear held through OUT meets the set in the same cycle and loses.
      r_clip <= ((r_state == S_OUT) && r_sat_evt) | (r_clip & ~clip_clear);
      case (r_state)
        S_IDLE: begin
          if (w_frame_start) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
              r_samp[i] <= voice_samples[16*i +: 16];
              r_gain[i] <= voice_gain[GAIN_BITS*i +: GAIN_BITS];
            end
            r_en     <= voice_enable;
            r_master <= master_gain;
            r_acc    <= '0;
            r_idx    <= '0;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + AW'(w_term);
          r_idx <= r_idx + 1'b1;
        end
        S_SCALE: begin
          r_mix     <= w_sat;
          r_sat_evt <= w_clip_evt;
          r_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer (4 voices, 8-bit gains).
module tb_voice_mixer;

  logic               mclk = 1'b0;
  logic               rst;
  logic               pblrc;
  logic [63:0]        vs;
  logic [31:0]        vg;
  logic [3:0]         ven;
  logic [7:0]         mg;
  logic               clip_clear;
  logic signed [15:0] mix_out;
  logic               mix_valid;
  logic               clip;
  logic               overrun;

  int errors = 0;
  int checks = 0;
  int pulses;

  voice_mixer #(.NUM_VOICES(4), .GAIN_BITS(8)) dut (
    .mclk          (mclk),
    .rst           (rst),
    .pblrc         (pblrc),
    .voice_samples (vs),
    .voice_gain    (vg),
    .voice_enable  (ven),
    .master_gain   (mg),
    .clip_clear    (clip_clear),
    .mix_out       (mix_out),
    .mix_valid     (mix_valid),
    .clip          (clip),
    .overrun       (overrun)
  );

  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setv(input int i, input int s, input int g, input bit e);
    vs[16*i +: 16] = 16'(s);
    vg[8*i +: 8]   = 8'(g);
    ven[i]         = e;
  endtask

  // Frame start in cycle E; result must appear exactly at E+6.
  task automatic frame_check(input string tag, input int exp_mix);
    pblrc = 1'b1;
    tick();
    pblrc = 1'b0;
    repeat (4) tick();
    chk({tag, "_valid_e5"}, mix_valid, 0);
    tick();
    chk({tag, "_valid_e6"}, mix_valid, 1);
    chk({tag, "_mix"}, mix_out, exp_mix);
    tick();
    chk({tag, "_valid_e7"}, mix_valid, 0);
  endtask

  initial begin
    rst = 1'b1; pblrc = 1'b0; vs = '0; vg = '0; ven = '0; mg = '0;
    clip_clear = 1'b0;
    repeat (2) tick();
    chk("rst_mix", mix_out, 0);
    chk("rst_valid", mix_valid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick();

    // Single voice at unity gain
    setv(0, 1000, 128, 1); setv(1, 0, 0, 0); setv(2, 0, 0, 0); setv(3, 0, 0, 0);
    mg = 8'd128;
    frame_check("single", 1000);
    chk("single_clip", clip, 0);
    tick();
    chk("single_hold", mix_out, 1000);

    // Positive saturation, then clear
    setv(0, 30000, 128, 1); setv(1, 30000, 128, 1);
    frame_check("possat", 32767);
    chk("possat_clip", clip, 1);
    clip_clear = 1'b1; tick(); clip_clear = 1'b0;
    chk("clip_cleared", clip, 0);

    // Clear held through OUT: set wins
    clip_clear = 1'b1;
    frame_check("possat2", 32767);
    chk("possat2_clip_e7", clip, 1);
    clip_clear = 1'b0;
    tick();
    chk("possat2_clip_after", clip, 1);
    clip_clear = 1'b1; tick(); clip_clear = 1'b0;

    // Negative saturation
    setv(0, -30000, 128, 1); setv(1, -30000, 128, 1);
    frame_check("negsat", -32768);
    chk("negsat_clip", clip, 1);
    clip_clear = 1'b1; tick(); clip_clear = 1'b0;

    // Floor rounding: -1 * 64/128 = -0.5 -> -1
    setv(0, -1, 64, 1); setv(1, 0, 0, 0);
    frame_check("floor", -1);
    chk("floor_clip", clip, 0);

    // All voices disabled
    ven = 4'h0;
    frame_check("disabled", 0);

    // Enable masking and snapshot: 200*255 - 300*64 = 31800; *200 >> 14 = 388
    setv(0, 200, 255, 1); setv(1, -300, 64, 1); setv(2, 5000, 128, 0); setv(3, 0, 0, 0);
    mg = 8'd200;
    pblrc = 1'b1;
    tick();
    pblrc = 1'b0;
    vs = {4{16'd7777}}; vg = {4{8'd128}}; ven = 4'hf; mg = 8'd255;
    repeat (5) tick();
    chk("snap_valid", mix_valid, 1);
    chk("snap_mix", mix_out, 388);
    tick();

    // Overrun: second edge at E+3 is ignored; 1000 * 64/128 = 500
    setv(0, 1000, 128, 1); setv(1, 0, 0, 0); setv(2, 0, 0, 0); setv(3, 0, 0, 0);
    mg = 8'd64;
    pblrc = 1'b1;
    tick();
    pblrc = 1'b0;
    repeat (2) tick();
    chk("ovr_before", overrun, 0);
    pblrc = 1'b1;
    tick();
    chk("ovr_set", overrun, 1);
    tick();
    chk("ovr_valid_e5", mix_valid, 0);
    tick();
    chk("ovr_valid_e6", mix_valid, 1);
    chk("ovr_mix", mix_out, 500);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mix_valid) pulses++;
    end
    chk("ovr_no_extra_frame", pulses, 0);
    pblrc = 1'b0;
    tick();

    // Reset mid-frame at E+3, pblrc held high across release
    pblrc = 1'b1;
    tick();
    pblrc = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    pblrc = 1'b1;
    #1;
    chk("midrst_mix", mix_out, 0);
    chk("midrst_valid", mix_valid, 0);
    chk("midrst_overrun", overrun, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mix_valid) pulses++;
    end
    chk("midrst_no_frame", pulses, 0);
    chk("midrst_mix_held", mix_out, 0);
    pblrc = 1'b0;
    tick();
    frame_check("after_rst", 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
